dct_mac_accum: RTL and testbench
================================

# dct_mac_accum

Multiply-accumulate back end of the DCTQ datapath. It sits directly downstream of the 8x8 signed multiplier and consumes its registered 16-bit signed products. It sums N_TERMS consecutive products into one DCT coefficient, then applies a rounding arithmetic right shift and saturates the result to OUT_W bits. Each coefficient is presented to the quantizer stage through a valid/ready handshake.

## Interface
- PROD_W, 16: product width (signed).
- N_TERMS, 8: products summed per coefficient.
- ACC_W, 19: accumulator width; must be ≥ PROD_W + clog2(N_TERMS).
- SHIFT, 3: rounding right shift applied to the sum; 0 = no shift.
- OUT_W, 12: output coefficient width (signed).
- N_COEF, 8: coefficients per row; out_idx wraps at N_COEF-1.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  in_prod carries a product. The upstream sequencer aligns it to the multiplier's one-cycle output register.
- in_ready  out  1  block accepts in_prod this cycle.
- in_prod  in  PROD_W  signed product.
- out_valid  out  1  out_coef/out_sat/out_idx valid.
- out_ready  in  1  downstream takes the output this cycle.
- out_coef  out  OUT_W  signed rounded, saturated coefficient.
- out_sat  out  1  saturation clipped this coefficient.
- out_idx  out  clog2(N_COEF)  coefficient index within the row.

## Operation
- Accept means in_valid && in_ready. Each accepted product is sign-extended to ACC_W and added to acc, and term_cnt increments.
- Final term (term_cnt == N_TERMS-1):
  - sum = acc + in_prod.
  - acc clears to 0 and term_cnt clears to 0.
  - The output register loads the rounded, saturated sum, out_idx loads coef_cnt, and coef_cnt increments, wrapping N_COEF-1 → 0.
- Rounding: computed at ACC_W+1 bits.
  - SHIFT > 0: r = (sum + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - SHIFT = 0: r = sum.
- Saturation:
  - r > 2^(OUT_W-1)-1 → out_coef = 2^(OUT_W-1)-1, out_sat = 1.
  - r < -2^(OUT_W-1) → out_coef = -2^(OUT_W-1), out_sat = 1.
  - Otherwise out_coef = r[OUT_W-1:0], out_sat = 0.
- The output register is a one-entry buffer. in_ready = !(term_cnt == N_TERMS-1 && out_valid && !out_ready). Non-final terms are always accepted.
- No explicit FSM beyond term_cnt/coef_cnt and the out_valid buffer state (EMPTY/FULL).

## Timing
- Reset values: acc=0, term_cnt=0, coef_cnt=0, out_valid=0, out_coef=0, out_sat=0, out_idx=0. in_ready reads 1 in reset.
- Latency: out_valid rises on the edge that accepts the final term, so outputs are visible the following cycle.
- Throughput: one product per cycle; one coefficient per N_TERMS cycles with no bubbles.
- While out_valid && !out_ready, out_coef/out_sat/out_idx hold stable.
- out_valid falls after an out_ready handshake unless a final term is accepted on the same edge.
- Simultaneous drain and final-term accept: the new coefficient loads and out_valid stays 1, with no bubble.
- in_valid=0 or in_ready=0: acc and term_cnt unchanged.
- Reset mid-group discards the partial sum and any pending output. coef_cnt restarts at 0.
- Full-scale sums fit ACC_W exactly (-262144 and 262136 with defaults). There is no accumulator overflow handling.

## Structure
- Shared package dctq_pkg holds:
  - DCTQ_PROD_W=16, DCTQ_ACC_W=19, DCTQ_OUT_W=12, DCTQ_N=8.
  - Signed typedefs for product, accumulator and coefficient.
- Sub-module dct_round_sat is a purely combinational shift/round/saturate on the ACC_W sum, producing coef and sat. The quantizer stage reuses it.
- Top level contains the counters, acc and the output buffer.

## Test plan
- Eight products of 100, out_ready=1 → out_coef=100 ((800+4)>>>3), out_sat=0, out_idx=0, out_valid high exactly the cycle after the 8th accept.
- Negative rounding:
  - Products -12 then seven 0 → out_coef=-1.
  - Products -13 then seven 0 → out_coef=-2.
- Saturation:
  - Eight 32767 → out_coef=2047, out_sat=1.
  - Eight -32768 → out_coef=-2048, out_sat=1.
- Backpressure: out_ready=0, continuous 16 products of 8.
  - First coefficient (8) is held stable.
  - in_ready drops at the 16th term and stays low.
  - Raising out_ready drains 8 and accepts the 16th term on the same edge; second coefficient 8 appears, out_valid never drops.
- Reset mid-group: 5 products of 1000, pulse rst asynchronously, then 8 products of 8 → out_coef=8, out_idx=0. No partial sum leaks.
- Index wrap: 9 back-to-back groups → out_idx sequence 0,1,…,7,0.

Source files
------------

// File: rtl/dctq_pkg.sv
// Shared DCTQ datapath widths and signed sample types.
package dctq_pkg;

    localparam int DCTQ_PROD_W = 16;
    localparam int DCTQ_ACC_W  = 19;
    localparam int DCTQ_OUT_W  = 12;
    localparam int DCTQ_N      = 8;

    typedef logic signed [DCTQ_PROD_W-1:0] prod_t;
    typedef logic signed [DCTQ_ACC_W-1:0]  acc_t;
    typedef logic signed [DCTQ_OUT_W-1:0]  coef_t;

endpackage

// File: rtl/dct_round_sat.sv
// Combinational rounding arithmetic right shift (half toward +inf) followed by
// saturation of an accumulator sum to a signed output coefficient.
module dct_round_sat
    import dctq_pkg::*;
#(
    parameter int ACC_W = DCTQ_ACC_W,
    parameter int OUT_W = DCTQ_OUT_W,
    parameter int SHIFT = 3
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic signed [OUT_W-1:0] coef_o,
    output logic                    sat_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_W + 1;
    // Half an LSB of the shifted result; evaluates to 0 when SHIFT is 0.
    localparam int HALF  = (1 << SHIFT) >> 1;

    localparam logic signed [EXT_W-1:0] MAX_E   = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_E   = ~MAX_E;
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
        logic signed [EXT_W-1:0] e;
        e = {s[ACC_W-1], s};
        e = e + EXT_W'(HALF);
        return e >>> SHIFT;
    endfunction

    // Result packs {sat, coef}.
    function automatic logic [OUT_W:0] saturate(input logic signed [EXT_W-1:0] r);
        if (r > MAX_E) begin
            return {1'b1, OUT_MAX};
        end else if (r < MIN_E) begin
            return {1'b1, OUT_MIN};
        end else begin
            return {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    // Round then clip the incoming sum.
    always_comb begin
        {sat_o, coef_o} = saturate(round_shift(sum_i));
    end

endmodule

// File: rtl/dct_mac_accum.sv
// Sums N_TERMS signed products into one DCT coefficient, rounds/saturates it
// and holds it in a one-entry valid/ready output buffer for the quantizer.
module dct_mac_accum
    import dctq_pkg::*;
#(
    parameter int PROD_W  = DCTQ_PROD_W,
    parameter int N_TERMS = DCTQ_N,
    parameter int ACC_W   = DCTQ_ACC_W,
    parameter int SHIFT   = 3,
    parameter int OUT_W   = DCTQ_OUT_W,
    parameter int N_COEF  = DCTQ_N,
    localparam int IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_coef,
    output logic                     out_sat,
    output logic [IDX_W-1:0]         out_idx
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        term_cnt_q, term_cnt_d;
    logic [IDX_W-1:0]        coef_cnt_q, coef_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_coef_q, out_coef_d;
    logic                    out_sat_q, out_sat_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;

    logic                    last_term;
    logic                    accept;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] rs_coef;
    logic                    rs_sat;

    // Only the final term of a group can stall, and only while the buffer is
    // full and not being drained on this edge.
    assign last_term = (term_cnt_q == CNT_W'(N_TERMS - 1));
    assign in_ready  = !(last_term && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign prod_ext  = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign sum       = acc_q + prod_ext;

    dct_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum_i  (sum),
        .coef_o (rs_coef),
        .sat_o  (rs_sat)
    );

    // Next-state: accumulate, close a group on its final term, manage the buffer.
    always_comb begin
        acc_d       = acc_q;
        term_cnt_d  = term_cnt_q;
        coef_cnt_d  = coef_cnt_q;
        out_valid_d = out_valid_q;
        out_coef_d  = out_coef_q;
        out_sat_d   = out_sat_q;
        out_idx_d   = out_idx_q;

        if (accept) begin
            if (last_term) begin
                acc_d      = '0;
                term_cnt_d = '0;
                coef_cnt_d = (coef_cnt_q == IDX_W'(N_COEF - 1)) ? '0 : coef_cnt_q + IDX_W'(1);
            end else begin
                acc_d      = sum;
                term_cnt_d = term_cnt_q + CNT_W'(1);
            end
        end

        // A new coefficient wins over a drain, so simultaneous drain+load keeps valid high.
        if (accept && last_term) begin
            out_valid_d = 1'b1;
            out_coef_d  = rs_coef;
            out_sat_d   = rs_sat;
            out_idx_d   = coef_cnt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any partial sum and pending coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            term_cnt_q  <= '0;
            coef_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_sat_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            term_cnt_q  <= term_cnt_d;
            coef_cnt_q  <= coef_cnt_d;
            out_valid_q <= out_valid_d;
            out_coef_q  <= out_coef_d;
            out_sat_q   <= out_sat_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_coef  = out_coef_q;
    assign out_sat   = out_sat_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_dct_mac_accum.sv
// Scoreboard bench for dct_mac_accum: the driver models groups of products
// with plain integer arithmetic and queues expected coefficients; an
// independent monitor pops and compares whenever the DUT hands one off.
module tb_dct_mac_accum;
    import dctq_pkg::*;

    localparam int NT   = 8;
    localparam int NC   = 8;
    localparam int DIV  = 8;     // 2**SHIFT
    localparam int OMAX = 2047;
    localparam int OMIN = -2048;

    typedef struct {
        int coef;
        bit sat;
        int idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    prod_t       in_prod;
    logic        out_valid;
    logic        out_ready;
    coef_t       out_coef;
    logic        out_sat;
    logic [2:0]  out_idx;

    dct_mac_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_sat   (out_sat),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nchecks = 0;
    int   nerrors = 0;
    exp_t sb[$];

    // Reference model state
    longint m_sum;
    int     m_cnt;
    int     m_idx;
    bit     m_full;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round half toward +inf via floor division, then clamp.
    function automatic exp_t make_exp(input longint s, input int idx);
        exp_t   e;
        longint q;
        longint r;
        q = s + DIV / 2;
        if (q >= 0) r = q / DIV;
        else        r = -((-q + DIV - 1) / DIV);
        e.sat = 1'b0;
        if (r > OMAX) begin
            r = OMAX; e.sat = 1'b1;
        end else if (r < OMIN) begin
            r = OMIN; e.sat = 1'b1;
        end
        e.coef = int'(r);
        e.idx  = idx;
        return e;
    endfunction

    // One clock of stimulus; acc reports whether the model expects acceptance.
    task automatic cycle(input bit v, input int p, input bit ordy, output bit acc);
        bit exp_rdy;
        bit drain;
        bit fin;
        @(negedge clk);
        in_valid  = v;
        in_prod   = prod_t'(p);
        out_ready = ordy;
        #3;
        exp_rdy = !(m_cnt == NT - 1 && m_full && !ordy);
        chk("in_ready", in_ready, exp_rdy);
        acc   = v && exp_rdy;
        drain = m_full && ordy;
        fin   = 1'b0;
        if (acc) begin
            m_sum += p;
            if (m_cnt == NT - 1) begin
                sb.push_back(make_exp(m_sum, m_idx));
                m_sum = 0;
                m_cnt = 0;
                m_idx = (m_idx + 1) % NC;
                fin   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        m_full = fin ? 1'b1 : (drain ? 1'b0 : m_full);
    endtask

    // Present a product until accepted, bounded by a cycle budget.
    task automatic send(input int p, input bit ordy);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            cycle(1'b1, p, ordy, acc);
            n++;
        end
        if (!acc) begin
            nchecks++;
            nerrors++;
            $display("FAIL send_timeout: got not-accepted expected accepted for %0d", p);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, ordy, acc);
    endtask

    task automatic group(input int first, input int rest);
        send(first, 1'b1);
        for (int i = 1; i < NT; i++) send(rest, 1'b1);
    endtask

    // Asynchronous reset pulse between clock edges, checking reset values.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        m_sum = 0; m_cnt = 0; m_idx = 0; m_full = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coef", out_coef, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_idx", out_idx, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: valid must track outstanding expectations; compare the head
    // every cycle it is presented and retire it on a handshake.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("out_valid", out_valid, (sb.size() != 0) ? 1 : 0);
            if (out_valid && sb.size() != 0) begin
                chk("out_coef", out_coef, sb[0].coef);
                chk("out_sat", out_sat, sb[0].sat);
                chk("out_idx", out_idx, sb[0].idx);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        logic signed [15:0] r16;
        rst = 1'b1;
        in_valid = 1'b0;
        in_prod = '0;
        out_ready = 1'b1;
        m_sum = 0; m_cnt = 0; m_idx = 0; m_full = 1'b0;

        do_reset();

        // Basic sum and rounding/saturation cases
        group(100, 100);
        group(-12, 0);
        group(-13, 0);
        group(32767, 32767);
        group(-32768, -32768);
        idle(3, 1'b1);

        // Backpressure: 15 terms land, the 16th stalls until the drain edge
        for (int i = 0; i < 15; i++) send(8, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8, 1'b0, acc);
        cycle(1'b1, 8, 1'b1, acc);
        chk("bp_final_accept", acc, 1);
        idle(3, 1'b1);

        // Reset mid-group discards the partial sum and restarts the index
        for (int i = 0; i < 5; i++) send(1000, 1'b1);
        do_reset();
        group(8, 8);
        idle(2, 1'b1);

        // Index wrap over nine back-to-back groups
        do_reset();
        for (int g = 0; g < 9; g++) begin
            for (int i = 0; i < NT; i++) begin
                r16 = 16'($urandom);
                send(int'(r16), 1'b1);
            end
        end
        idle(2, 1'b1);

        // Random valid, backpressure and products
        for (int i = 0; i < 600; i++) begin
            r16 = ($urandom_range(0, 3) == 0) ? 16'sh7fff : 16'($urandom);
            cycle($urandom_range(0, 3) != 0, int'(r16), $urandom_range(0, 2) != 0, acc);
        end
        idle(4, 1'b1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
